game_round_ctrl: RTL and testbench
==================================

// Module: game_round_ctrl
// PURPOSE
//  Round sequencer feeding the game state machine: owns the round countdown, life counter,
//  post-hit invulnerability window and 1 Hz tick. Produces one_sec_pulse, time_end and
//  life_over for the game FSM and is told to start/stop rounds by it. One instance per design.
// PARAMETERS
//  CLK_FREQ      31_500_000  clk cycles per second (prescaler terminal count +1), >=2
//  ROUND_SECONDS 60          countdown load value, 1..99
//  LIVES         3           lives per round, 1..7
//  INVULN_SEC    1           seconds hits are ignored after a counted hit, 1..7
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-high reset
//  round_start   in   1  1-cycle pulse: (re)start a round
//  round_stop    in   1  level/pulse: freeze round (game FSM in winner/loser state)
//  hit_pulse     in   1  1-cycle pulse: player hit by hazard
//  one_sec_pulse out  1  1-cycle tick every CLK_FREQ clk
//  seconds_left  out  7  remaining round seconds, binary
//  lives_left    out  3  remaining lives, binary
//  invuln        out  1  high during invulnerability window
//  time_end      out  1  level: countdown reached 0 this round
//  life_over     out  1  level: lives reached 0 this round
// BEHAVIOUR
//  Clock/reset: one clock, reset synchronous active-high; all state updates on posedge clk.
//  Reset values: state=IDLE, prescaler=0, one_sec_pulse=0, seconds_left=ROUND_SECONDS,
//   lives_left=LIVES, invuln=0, time_end=0, life_over=0, invuln counter=0.
//  Prescaler: held 0 in IDLE; in RUN/INVULN/DONE counts 0..CLK_FREQ-1, wraps to 0;
//   one_sec_pulse=1 for exactly the cycle after count==CLK_FREQ-1 (registered). It keeps
//   ticking in DONE so the game FSM can time its end screen.
//  FSM states: IDLE, RUN, INVULN, DONE.
//   IDLE  : outputs hold; round_start -> RUN.
//   RUN   : on one_sec_pulse seconds_left-=1; when it becomes 0 -> time_end=1, DONE.
//           hit_pulse: lives_left-=1; if result 0 -> life_over=1, DONE; else invuln=1,
//           inv_cnt=INVULN_SEC, -> INVULN.
//   INVULN: countdown continues as in RUN; hit_pulse ignored; on one_sec_pulse inv_cnt-=1;
//           inv_cnt reaching 0 -> invuln=0, RUN. Countdown expiry -> DONE (invuln=0).
//   DONE  : counters frozen, flags held; round_start only exit.
//  Priority (high->low): reset, round_start, round_stop, expiry/hit events.
//  round_start in any state: prescaler=0, seconds_left=ROUND_SECONDS, lives_left=LIVES,
//   flags and invuln cleared, -> RUN next cycle (restart mid-round allowed).
//  round_stop in RUN/INVULN -> DONE, flags unchanged, invuln=0; ignored in IDLE/DONE.
//  Simultaneous tick-to-0 and final-life hit in RUN: both applied same cycle, time_end=1
//   AND life_over=1, -> DONE. Non-final hit with tick-to-0: life decremented, time_end=1, DONE.
//  Counters never underflow: no decrement when already 0. one_sec_pulse never
//   asserted in IDLE or the cycle reset is applied.
// CONFIGURATION
//  GAME_ROUND_PAUSE_EN defined: adds input pause (1 bit). While pause=1 in RUN/INVULN the
//   prescaler, seconds_left and inv_cnt freeze, one_sec_pulse=0, hit_pulse ignored; state
//   held; release resumes from frozen prescaler value. round_start/round_stop still obeyed.
//  Not defined: no pause port; block behaves as above unconditionally.
// TESTING (CLK_FREQ=10, ROUND_SECONDS=5, LIVES=2, INVULN_SEC=2 unless stated)
//  1. reset 1 cycle, round_start -> one_sec_pulse every 10 clk; seconds_left 5..0 over 50 clk;
//     time_end=1 on 5th pulse, state DONE, pulses continue, seconds_left stays 0.
//  2. hit at t=3 clk -> lives_left=1, invuln=1; hit at t=15 ignored (lives 1); invuln=0
//     after 2nd pulse; hit afterwards -> lives_left=0, life_over=1, DONE.
//  3. ROUND_SECONDS=1, LIVES=1: hit_pulse on cycle of final tick -> time_end=1, life_over=1
//     same cycle, lives_left=0, seconds_left=0.
//  4. round_start at seconds_left=2, lives_left=1 -> next cycle seconds_left=5, lives_left=2,
//     flags 0, prescaler restarts (next pulse 10 clk later).
//  5. round_stop at seconds_left=3 -> DONE; seconds_left stays 3, no flags; reset mid-round
//     -> all outputs to reset values next cycle.
//  6. GAME_ROUND_PAUSE_EN: pause 25 clk at seconds_left=4 -> no pulses, values frozen; hit
//     ignored; after release next pulse at remaining prescaler distance.

Source files
------------

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for the game FSM.
// Owns the round countdown, the life counter, the post-hit invulnerability window and a
// 1 Hz tick derived from a prescaler.
//
// Optional feature: define GAME_ROUND_PAUSE_EN to add a 'pause' input that freezes the
// round (prescaler, countdown, invulnerability timer) and ignores hits while in RUN/INVULN.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   round_start   in   1-cycle pulse, (re)start a round from any state
//   round_stop    in   freeze the round (RUN/INVULN -> DONE)
//   hit_pulse     in   1-cycle pulse, player hit
//   pause         in   (GAME_ROUND_PAUSE_EN only) freeze the running round
//   one_sec_pulse out  1-cycle tick every CLK_FREQ clocks (not in IDLE)
//   seconds_left  out  remaining round seconds
//   lives_left    out  remaining lives
//   invuln        out  invulnerability window active
//   time_end      out  countdown reached 0 this round
//   life_over     out  lives reached 0 this round
module game_round_ctrl #(
  parameter int unsigned CLK_FREQ      = 31_500_000,
  parameter int unsigned ROUND_SECONDS = 60,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned INVULN_SEC    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       round_start,
  input  logic       round_stop,
  input  logic       hit_pulse,
`ifdef GAME_ROUND_PAUSE_EN
  input  logic       pause,
`endif
  output logic       one_sec_pulse,
  output logic [6:0] seconds_left,
  output logic [2:0] lives_left,
  output logic       invuln,
  output logic       time_end,
  output logic       life_over
);

  localparam int unsigned PW = $clog2(CLK_FREQ);

  typedef enum logic [1:0] {StIdle, StRun, StInvuln, StDone} state_e;

  state_e          state;
  logic [PW-1:0]   presc;
  logic [2:0]      inv_cnt;

  logic            paused;
  logic            wrap;
  logic            hit_eff;
  logic            expire;
  logic [6:0]      sec_dec;
  logic [2:0]      lives_dec;
  logic [PW-1:0]   presc_next;

`ifdef GAME_ROUND_PAUSE_EN
  always_comb paused = pause;
`else
  always_comb paused = 1'b0;
`endif

  always_comb begin
    wrap       = (presc == PW'(CLK_FREQ - 1));
    presc_next = wrap ? '0 : presc + PW'(1);
    // Hits only count in RUN; INVULN swallows them.
    hit_eff    = hit_pulse && (state == StRun);
    sec_dec    = (wrap && seconds_left != 7'd0) ? seconds_left - 7'd1 : seconds_left;
    lives_dec  = (hit_eff && lives_left != 3'd0) ? lives_left - 3'd1 : lives_left;
    expire     = wrap && (seconds_left == 7'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= StIdle;
      presc         <= '0;
      one_sec_pulse <= 1'b0;
      seconds_left  <= 7'(ROUND_SECONDS);
      lives_left    <= 3'(LIVES);
      invuln        <= 1'b0;
      time_end      <= 1'b0;
      life_over     <= 1'b0;
      inv_cnt       <= 3'd0;
    end else if (round_start) begin
      state         <= StRun;
      presc         <= '0;
      one_sec_pulse <= 1'b0;
      seconds_left  <= 7'(ROUND_SECONDS);
      lives_left    <= 3'(LIVES);
      invuln        <= 1'b0;
      time_end      <= 1'b0;
      life_over     <= 1'b0;
      inv_cnt       <= 3'd0;
    end else begin
      unique case (state)
        StIdle: begin
          one_sec_pulse <= 1'b0;
        end
        StDone: begin
          // Tick keeps running so the game FSM can time its end screen.
          presc         <= presc_next;
          one_sec_pulse <= wrap;
        end
        StRun, StInvuln: begin
          if (round_stop) begin
            presc         <= paused ? presc : presc_next;
            one_sec_pulse <= wrap && !paused;
            invuln        <= 1'b0;
            state         <= StDone;
          end else if (paused) begin
            one_sec_pulse <= 1'b0;
          end else begin
            presc         <= presc_next;
            one_sec_pulse <= wrap;
            seconds_left  <= sec_dec;
            lives_left    <= lives_dec;
            if (expire) begin
              // Countdown expiry wins, but a same-cycle hit is still applied.
              time_end <= 1'b1;
              invuln   <= 1'b0;
              state    <= StDone;
              if (hit_eff && lives_dec == 3'd0) life_over <= 1'b1;
            end else if (hit_eff) begin
              if (lives_dec == 3'd0) begin
                life_over <= 1'b1;
                state     <= StDone;
              end else begin
                invuln  <= 1'b1;
                inv_cnt <= 3'(INVULN_SEC);
                state   <= StInvuln;
              end
            end else if (state == StInvuln && wrap) begin
              if (inv_cnt <= 3'd1) begin
                inv_cnt <= 3'd0;
                invuln  <= 1'b0;
                state   <= StRun;
              end else begin
                inv_cnt <= inv_cnt - 3'd1;
              end
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
module tb_game_round_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0, stop1 = 1'b0, hit1 = 1'b0;
  logic start2 = 1'b0, stop2 = 1'b0, hit2 = 1'b0;
  logic pause1 = 1'b0, pause2 = 1'b0;

  logic       p1, p2, inv1, inv2, te1, te2, lo1, lo2;
  logic [6:0] sec1, sec2;
  logic [2:0] lv1, lv2;

  always #5 clk = ~clk;

  game_round_ctrl #(.CLK_FREQ(10), .ROUND_SECONDS(5), .LIVES(2), .INVULN_SEC(2)) dut (
    .clk(clk), .reset(reset), .round_start(start1), .round_stop(stop1), .hit_pulse(hit1),
`ifdef GAME_ROUND_PAUSE_EN
    .pause(pause1),
`endif
    .one_sec_pulse(p1), .seconds_left(sec1), .lives_left(lv1), .invuln(inv1),
    .time_end(te1), .life_over(lo1)
  );

  game_round_ctrl #(.CLK_FREQ(10), .ROUND_SECONDS(1), .LIVES(1), .INVULN_SEC(2)) dut2 (
    .clk(clk), .reset(reset), .round_start(start2), .round_stop(stop2), .hit_pulse(hit2),
`ifdef GAME_ROUND_PAUSE_EN
    .pause(pause2),
`endif
    .one_sec_pulse(p2), .seconds_left(sec2), .lives_left(lv2), .invuln(inv2),
    .time_end(te2), .life_over(lo2)
  );

  typedef struct {
    string name;
    int    at;
    bit    which;
    int    sec;
    int    lives;
    bit    inv;
    bit    te;
    bit    lo;
    bit    p;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: pops every expectation due this cycle and compares.
  exp_t e;
  int   a_sec, a_lv;
  bit   a_inv, a_te, a_lo, a_p;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      tests++;
      if (e.at < cyc) begin
        fails++;
        $display("FAIL %s stale expectation for cycle %0d seen at %0d", e.name, e.at, cyc);
      end else begin
        a_sec = e.which ? int'(sec2) : int'(sec1);
        a_lv  = e.which ? int'(lv2) : int'(lv1);
        a_inv = e.which ? inv2 : inv1;
        a_te  = e.which ? te2 : te1;
        a_lo  = e.which ? lo2 : lo1;
        a_p   = e.which ? p2 : p1;
        if (a_sec != e.sec || a_lv != e.lives || a_inv != e.inv || a_te != e.te ||
            a_lo != e.lo || a_p != e.p) begin
          fails++;
          $display("FAIL %s cyc=%0d got sec=%0d lives=%0d inv=%0d te=%0d lo=%0d pulse=%0d %s",
                   e.name, cyc, a_sec, a_lv, a_inv, a_te, a_lo, a_p,
                   $sformatf("want sec=%0d lives=%0d inv=%0d te=%0d lo=%0d pulse=%0d",
                             e.sec, e.lives, e.inv, e.te, e.lo, e.p));
        end
      end
    end
  end

  task automatic expect_at(input string name, input bit which, input int at, input int sec,
                           input int lives, input bit inv, input bit te, input bit lo,
                           input bit p);
    exp_t x;
    x.name = name; x.which = which; x.at = at; x.sec = sec; x.lives = lives;
    x.inv = inv; x.te = te; x.lo = lo; x.p = p;
    q.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int at);
    while (cyc < at) step(1);
  endtask

  // Returns the cycle whose posedge sampled round_start.
  task automatic start(input bit which, output int s);
    if (which) start2 = 1'b1; else start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    start2 = 1'b0;
    s = cyc;
  endtask

  // Hit sampled by the posedge that ends at cycle 'at'.
  task automatic hit_at(input bit which, input int at);
    run_to(at - 1);
    if (which) hit2 = 1'b1; else hit1 = 1'b1;
    step(1);
    hit1 = 1'b0;
    hit2 = 1'b0;
  endtask

  int s;

  initial begin
    // Reset and idle
    step(1);
    reset = 1'b0;
    expect_at("reset", 0, cyc, 5, 2, 0, 0, 0, 0);
    expect_at("reset2", 1, cyc, 1, 1, 0, 0, 0, 0);
    expect_at("idle_no_tick", 0, cyc + 12, 5, 2, 0, 0, 0, 0);
    run_to(cyc + 13);

    // Plain countdown to expiry
    start(0, s);
    expect_at("t1_start", 0, s, 5, 2, 0, 0, 0, 0);
    expect_at("t1_pre", 0, s + 9, 5, 2, 0, 0, 0, 0);
    expect_at("t1_tick1", 0, s + 10, 4, 2, 0, 0, 0, 1);
    expect_at("t1_tick1_end", 0, s + 11, 4, 2, 0, 0, 0, 0);
    expect_at("t1_tick4", 0, s + 40, 1, 2, 0, 0, 0, 1);
    expect_at("t1_pre_end", 0, s + 49, 1, 2, 0, 0, 0, 0);
    expect_at("t1_expire", 0, s + 50, 0, 2, 0, 1, 0, 1);
    expect_at("t1_done_tick", 0, s + 60, 0, 2, 0, 1, 0, 1);
    run_to(s + 61);

    // Hits and invulnerability
    start(0, s);
    expect_at("t2_hit1", 0, s + 3, 5, 1, 1, 0, 0, 0);
    expect_at("t2_inv_tick", 0, s + 10, 4, 1, 1, 0, 0, 1);
    expect_at("t2_hit_ignored", 0, s + 15, 4, 1, 1, 0, 0, 0);
    expect_at("t2_inv_hold", 0, s + 19, 4, 1, 1, 0, 0, 0);
    expect_at("t2_inv_end", 0, s + 20, 3, 1, 0, 0, 0, 1);
    expect_at("t2_last_life", 0, s + 25, 3, 0, 0, 0, 1, 0);
    expect_at("t2_done_frozen", 0, s + 30, 3, 0, 0, 0, 1, 1);
    hit_at(0, s + 3);
    hit_at(0, s + 15);
    hit_at(0, s + 25);
    run_to(s + 31);

    // Non-final hit on the expiring tick
    start(0, s);
    expect_at("t7_hit_on_expiry", 0, s + 50, 0, 1, 0, 1, 0, 1);
    hit_at(0, s + 50);
    run_to(s + 51);

    // Restart mid-round
    start(0, s);
    expect_at("t4_hit", 0, s + 3, 5, 1, 1, 0, 0, 0);
    expect_at("t4_sec2", 0, s + 30, 2, 1, 0, 0, 0, 1);
    expect_at("t4_restart", 0, s + 35, 5, 2, 0, 0, 0, 0);
    expect_at("t4_restart_pre", 0, s + 44, 5, 2, 0, 0, 0, 0);
    expect_at("t4_restart_tick", 0, s + 45, 4, 2, 0, 0, 0, 1);
    hit_at(0, s + 3);
    run_to(s + 34);
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    run_to(s + 46);

    // round_stop, then reset mid-round
    start(0, s);
    expect_at("t5_sec3", 0, s + 20, 3, 2, 0, 0, 0, 1);
    expect_at("t5_stop", 0, s + 25, 3, 2, 0, 0, 0, 0);
    expect_at("t5_stop_tick", 0, s + 30, 3, 2, 0, 0, 0, 1);
    expect_at("t5_stop_frozen", 0, s + 40, 3, 2, 0, 0, 0, 1);
    run_to(s + 24);
    stop1 = 1'b1;
    step(1);
    stop1 = 1'b0;
    run_to(s + 41);

    start(0, s);
    expect_at("t5_pre_reset", 0, s + 12, 4, 1, 1, 0, 0, 0);
    expect_at("t5_reset", 0, s + 13, 5, 2, 0, 0, 0, 0);
    expect_at("t5_reset_idle", 0, s + 30, 5, 2, 0, 0, 0, 0);
    hit_at(0, s + 3);
    run_to(s + 12);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    run_to(s + 31);

    // Simultaneous final tick and final hit (1 s, 1 life)
    start(1, s);
    expect_at("t3_pre", 1, s + 9, 1, 1, 0, 0, 0, 0);
    expect_at("t3_both", 1, s + 10, 0, 0, 0, 1, 1, 1);
    expect_at("t3_no_underflow", 1, s + 15, 0, 0, 0, 1, 1, 0);
    hit_at(1, s + 10);
    hit_at(1, s + 15);
    run_to(s + 16);

`ifdef GAME_ROUND_PAUSE_EN
    // Pause for 25 cycles starting at seconds_left=4
    start(0, s);
    expect_at("t6_sec4", 0, s + 10, 4, 2, 0, 0, 0, 1);
    expect_at("t6_pause_hit", 0, s + 25, 4, 2, 0, 0, 0, 0);
    expect_at("t6_pause_no_tick", 0, s + 37, 4, 2, 0, 0, 0, 0);
    expect_at("t6_resume_pre", 0, s + 44, 4, 2, 0, 0, 0, 0);
    expect_at("t6_resume_tick", 0, s + 45, 3, 2, 0, 0, 0, 1);
    run_to(s + 12);
    pause1 = 1'b1;
    hit_at(0, s + 25);
    run_to(s + 37);
    pause1 = 1'b0;
    run_to(s + 46);
`endif

    step(3);
    while (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      fails++;
      $display("FAIL %s never checked (due cycle %0d, now %0d)", e.name, e.at, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
